// File: rtl/dmux_router.sv
// Registered 1-to-N demultiplexer with valid/ready flow control, per-channel
// one-word output registers, broadcast mode and a saturating drop counter.

module dmux_router_ch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A load wins over a drain, so drain+load on one edge keeps the channel full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

module dmux_router #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int CNTW  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               in_bcast,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [CNTW-1:0]    drop_cnt
);
    localparam logic [31:0] NCH = 32'(N);

    logic [N-1:0]    hit;
    logic [N-1:0]    free;
    logic            sel_ok;
    logic            accept;
    logic            drop;
    logic [CNTW-1:0] cnt_q, cnt_d;

    assign free   = ~out_valid | out_ready;
    assign sel_ok = (32'(in_sel) < NCH);

    // Unicast to a missing channel is always accepted and thrown away.
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast)
            in_ready = &free;
        else if (sel_ok)
            in_ready = |(hit & free);
    end

    assign accept = in_valid & in_ready;
    assign drop   = accept & ~in_bcast & ~sel_ok;

    for (genvar k = 0; k < N; k++) begin : g_ch
        assign hit[k] = in_bcast | (in_sel == SELW'(k));

        dmux_router_ch #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (accept & hit[k]),
            .ready_i (out_ready[k]),
            .data_i  (in_data),
            .valid_o (out_valid[k]),
            .data_o  (out_data[k*WIDTH +: WIDTH])
        );
    end

    always_comb begin
        cnt_d = cnt_q;
        if (drop && (cnt_q != {CNTW{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign drop_cnt = cnt_q;
endmodule
